// File: rtl/accum_sched_pkg.sv
// Shared types and default sizes for the round-robin accumulator scheduler.
package accum_sched_pkg;

  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned WIDTH_DEF = 4;

  typedef enum logic {OP_ADD, OP_CLEAR} acc_op_e;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_RESP} sched_state_e;

endpackage

// File: rtl/accum_sched_if.sv
// Request and response channels between the requesters and the accumulator scheduler.
interface accum_sched_if
  import accum_sched_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF
);
  localparam int unsigned ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_op;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic                   resp_valid;
  logic [ID_W-1:0]        resp_id;
  logic [WIDTH-1:0]       resp_sum;
  logic                   resp_carry;
  logic                   resp_ready;

  modport master (
    output req_valid, req_op, req_data, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_sum, resp_carry
  );

  modport slave (
    input  req_valid, req_op, req_data, resp_ready,
    output req_ready, resp_valid, resp_id, resp_sum, resp_carry
  );

endinterface

// File: rtl/accum_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned ID_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  logic [ID_W-1:0] k;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      k = ID_W'((32'(ptr) + i) % N_REQ);
      if (!any && req[k]) begin
        any    = 1'b1;
        idx    = k;
        gnt[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/accum_sched.sv
// Shares one registered accumulator between N_REQ requesters: grant, accumulate, respond.
module accum_sched
  import accum_sched_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  accum_sched_if.slave     bus,
  output logic [WIDTH-1:0] acc_sum,
  output logic             busy
);

  localparam int unsigned ID_W = $clog2(N_REQ);

  sched_state_e     state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  acc_op_e          op_q, op_d;

  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_idx;
  logic             gnt_any;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req (bus.req_valid),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    id_d           = id_q;
    operand_d      = operand_q;
    acc_d          = acc_q;
    carry_d        = carry_q;
    op_d           = op_q;
    bus.req_ready  = '0;
    bus.resp_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Gating with rst keeps a reset cycle from emitting an accept pulse.
        if (gnt_any && !rst) begin
          bus.req_ready = gnt;
          operand_d     = bus.req_data[gnt_idx*WIDTH +: WIDTH];
          op_d          = acc_op_e'(bus.req_op[gnt_idx]);
          id_d          = gnt_idx;
          ptr_d         = (gnt_idx == ID_W'(N_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
          state_d       = S_ACC;
        end
      end
      S_ACC: begin
        if (op_q == OP_ADD) begin
          {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, operand_q};
        end else begin
          acc_d   = '0;
          carry_d = 1'b0;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        bus.resp_valid = !rst;
        if (bus.resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      operand_q <= '0;
      acc_q     <= '0;
      carry_q   <= 1'b0;
      op_q      <= OP_ADD;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      operand_q <= operand_d;
      acc_q     <= acc_d;
      carry_q   <= carry_d;
      op_q      <= op_d;
    end
  end

  assign bus.resp_id    = id_q;
  assign bus.resp_sum   = acc_q;
  assign bus.resp_carry = carry_q;
  assign acc_sum        = acc_q;
  assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_accum_sched.sv
// Self-checking bench for accum_sched: per-scenario tasks plus a response scoreboard.
module tb_accum_sched;
  import accum_sched_pkg::*;

  localparam int unsigned N = 4;
  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] acc_sum;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int           id;
    logic [W-1:0] sum;
    logic         carry;
  } exp_t;

  exp_t         sb[$];
  exp_t         e_mon;
  logic [W-1:0] acc_m = '0;

  accum_sched_if #(.N_REQ(N), .WIDTH(W)) bus();

  accum_sched #(.N_REQ(N), .WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .acc_sum (acc_sum),
    .busy    (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void model_push(input int id, input logic op, input logic [W-1:0] d);
    exp_t   e;
    logic [W:0] s;
    if (op == OP_ADD) s = {1'b0, acc_m} + {1'b0, d};
    else              s = '0;
    acc_m   = s[W-1:0];
    e.id    = id;
    e.sum   = s[W-1:0];
    e.carry = s[W];
    sb.push_back(e);
  endfunction

  // Scoreboard: every completed response handshake is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.resp_valid === 1'b1 && bus.resp_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: got id=%0d sum=%h carry=%b, required no response",
                 bus.resp_id, bus.resp_sum, bus.resp_carry);
      end else begin
        e_mon = sb.pop_front();
        if (int'(bus.resp_id) !== e_mon.id || bus.resp_sum !== e_mon.sum ||
            bus.resp_carry !== e_mon.carry) begin
          errors++;
          $display("FAIL resp_data: got id=%0d sum=%h carry=%b, required id=%0d sum=%h carry=%b",
                   bus.resp_id, bus.resp_sum, bus.resp_carry, e_mon.id, e_mon.sum, e_mon.carry);
        end
      end
    end
  end

  task automatic issue(input int id, input logic op, input logic [W-1:0] d,
                       output int gcyc, output logic [N-1:0] gv);
    bit got = 0;
    gcyc = -1;
    gv   = '0;
    bus.req_valid[id]      = 1'b1;
    bus.req_op[id]         = op;
    bus.req_data[id*W +: W] = d;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (bus.req_ready[id] === 1'b1) begin
        got  = 1;
        gcyc = cyc;
        gv   = bus.req_ready;
        model_push(id, op, d);
        break;
      end
      @(posedge clk);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL grant_timeout: got no req_ready for req%0d, required a grant within 20 cycles", id);
    end
    @(posedge clk);
    #1 bus.req_valid[id] = 1'b0;
    #1;
  endtask

  task automatic wait_resp(output int rcyc);
    rcyc = -1;
    for (int n = 0; n < 20; n++) begin
      if (bus.resp_valid === 1'b1) begin
        rcyc = cyc;
        break;
      end
      @(posedge clk);
      #2;
    end
    checks++;
    if (rcyc < 0) begin
      errors++;
      $display("FAIL resp_timeout: got no resp_valid, required one within 20 cycles");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks += 4;
    if (acc_sum !== '0) begin errors++; $display("FAIL rst_acc: got %h, required 0", acc_sum); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
    if (bus.req_ready !== '0) begin errors++; $display("FAIL rst_ready: got %b, required 0000", bus.req_ready); end
    if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b, required 0", bus.resp_valid); end
  endtask

  task automatic test_single_add();
    int g, r;
    logic [N-1:0] gv;
    issue(0, OP_ADD, 4'h5, g, gv);
    checks++;
    if (gv !== 4'b0001) begin errors++; $display("FAIL add_gnt: got %b, required 0001", gv); end
    wait_resp(r);
    checks += 2;
    if (r - g !== 2) begin errors++; $display("FAIL add_latency: got %0d, required 2", r - g); end
    if (bus.resp_id !== 2'd0 || bus.resp_sum !== 4'h5 || bus.resp_carry !== 1'b0) begin
      errors++;
      $display("FAIL add_resp: got id=%0d sum=%h carry=%b, required id=0 sum=5 carry=0",
               bus.resp_id, bus.resp_sum, bus.resp_carry);
    end
    @(posedge clk); #2;
  endtask

  task automatic test_wrap_clear();
    int g, r;
    logic [N-1:0] gv;
    issue(1, OP_ADD, 4'h7, g, gv);
    wait_resp(r);
    @(posedge clk); #2;
    checks++;
    if (acc_sum !== 4'hC) begin errors++; $display("FAIL pre_wrap_acc: got %h, required c", acc_sum); end
    issue(2, OP_ADD, 4'h7, g, gv);
    wait_resp(r);
    checks++;
    if (bus.resp_sum !== 4'h3 || bus.resp_carry !== 1'b1) begin
      errors++;
      $display("FAIL wrap: got sum=%h carry=%b, required sum=3 carry=1", bus.resp_sum, bus.resp_carry);
    end
    @(posedge clk); #2;
    issue(2, OP_CLEAR, 4'hF, g, gv);
    wait_resp(r);
    checks++;
    if (bus.resp_sum !== 4'h0 || bus.resp_carry !== 1'b0) begin
      errors++;
      $display("FAIL clear: got sum=%h carry=%b, required sum=0 carry=0", bus.resp_sum, bus.resp_carry);
    end
    @(posedge clk); #2;
    checks++;
    if (acc_sum !== 4'h0) begin errors++; $display("FAIL clear_acc: got %h, required 0", acc_sum); end
  endtask

  task automatic test_round_robin();
    int gid[5];
    int gc[5];
    int ng = 0;
    int r;
    int exp_id[5] = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    repeat (2) @(posedge clk);
    sb.delete();
    acc_m = '0;
    #1 rst = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      bus.req_valid[i]      = 1'b1;
      bus.req_op[i]         = OP_ADD;
      bus.req_data[i*W +: W] = W'(i + 1);
    end
    #1;
    for (int n = 0; n < 40 && ng < 5; n++) begin
      if (|bus.req_ready) begin
        checks++;
        if ($countones(bus.req_ready) != 1) begin
          errors++;
          $display("FAIL rr_onehot: got %b, required one-hot", bus.req_ready);
        end
        for (int b = 0; b < int'(N); b++) if (bus.req_ready[b]) gid[ng] = b;
        gc[ng] = cyc;
        model_push(gid[ng], OP_ADD, W'(gid[ng] + 1));
        ng++;
      end
      if (ng < 5) begin
        @(posedge clk); #2;
      end
    end
    @(posedge clk);
    #1 bus.req_valid = '0;
    #1;
    checks++;
    if (ng != 5) begin errors++; $display("FAIL rr_count: got %0d grants, required 5", ng); end
    for (int i = 0; i < ng; i++) begin
      checks++;
      if (gid[i] != exp_id[i]) begin
        errors++;
        $display("FAIL rr_order[%0d]: got req%0d, required req%0d", i, gid[i], exp_id[i]);
      end
      if (i > 0) begin
        checks++;
        if (gc[i] - gc[i-1] != 3) begin
          errors++;
          $display("FAIL rr_spacing[%0d]: got %0d cycles, required 3", i, gc[i] - gc[i-1]);
        end
      end
    end
    wait_resp(r);
    @(posedge clk); #2;
  endtask

  task automatic test_backpressure();
    int g, r;
    logic [N-1:0] gv;
    logic [1:0]   id0;
    logic [W-1:0] sum0;
    logic         c0;
    bus.resp_ready = 1'b0;
    issue(0, OP_ADD, 4'h9, g, gv);
    wait_resp(r);
    id0  = bus.resp_id;
    sum0 = bus.resp_sum;
    c0   = bus.resp_carry;
    checks++;
    if (id0 !== 2'd0 || sum0 !== 4'h4 || c0 !== 1'b1) begin
      errors++;
      $display("FAIL bp_resp: got id=%0d sum=%h carry=%b, required id=0 sum=4 carry=1", id0, sum0, c0);
    end
    bus.req_valid[1]      = 1'b1;
    bus.req_op[1]         = OP_ADD;
    bus.req_data[1*W +: W] = 4'h2;
    for (int n = 0; n < 5; n++) begin
      #1;
      checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_id !== id0 || bus.resp_sum !== sum0 ||
          bus.resp_carry !== c0 || busy !== 1'b1 || bus.req_ready !== '0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got valid=%b id=%0d sum=%h carry=%b busy=%b ready=%b, required 1 %0d %h %b 1 0000",
                 n, bus.resp_valid, bus.resp_id, bus.resp_sum, bus.resp_carry, busy, bus.req_ready,
                 id0, sum0, c0);
      end
      @(posedge clk); #1;
    end
    bus.resp_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== '0) begin errors++; $display("FAIL bp_same_cycle: got %b, required 0000", bus.req_ready); end
    @(posedge clk); #2;
    checks++;
    if (bus.req_ready !== 4'b0010 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_regrant: got ready=%b busy=%b, required ready=0010 busy=0", bus.req_ready, busy);
    end
    if (bus.req_ready[1] === 1'b1) model_push(1, OP_ADD, 4'h2);
    @(posedge clk);
    #1 bus.req_valid[1] = 1'b0;
    #1;
    wait_resp(r);
    @(posedge clk); #2;
  endtask

  task automatic test_reset_mid_op();
    int g;
    int r;
    logic [N-1:0] gv;
    issue(1, OP_ADD, 4'h3, g, gv);
    rst = 1'b1;
    @(posedge clk); #1;
    sb.delete();
    acc_m = '0;
    checks++;
    if (acc_sum !== '0 || busy !== 1'b0 || bus.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state: got acc=%h busy=%b rvalid=%b, required 0 0 0", acc_sum, busy, bus.resp_valid);
    end
    bus.req_valid[1]      = 1'b1;
    bus.req_op[1]         = OP_ADD;
    bus.req_data[1*W +: W] = 4'h5;
    bus.req_valid[3]      = 1'b1;
    bus.req_op[3]         = OP_ADD;
    bus.req_data[3*W +: W] = 4'h6;
    #1;
    checks++;
    if (bus.req_ready !== '0) begin errors++; $display("FAIL midrst_ready: got %b, required 0000", bus.req_ready); end
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0010 || bus.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ptr: got ready=%b rvalid=%b, required ready=0010 rvalid=0", bus.req_ready, bus.resp_valid);
    end
    if (bus.req_ready[1] === 1'b1) model_push(1, OP_ADD, 4'h5);
    @(posedge clk);
    #1 bus.req_valid = '0;
    #1;
    wait_resp(r);
    @(posedge clk); #2;
  endtask

  initial begin
    bus.req_valid  = '0;
    bus.req_op     = '0;
    bus.req_data   = '0;
    bus.resp_ready = 1'b1;
    test_reset();
    test_single_add();
    test_wrap_clear();
    test_round_robin();
    test_backpressure();
    test_reset_mid_op();
    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d outstanding responses, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
